key_event_gen: RTL and testbench
================================

// Module: key_event_gen
// PURPOSE
//  Conditions the raw active-low push-button key_n ahead of SM_top's display state machine.
//  Synchronises and debounces the key, then classifies each press as short or long.
//  Emits single-cycle event strobes, including auto-repeat while the key stays held.
//  Keeps a wrapping display-mode index that SM_top uses to select its pattern.
// PARAMETERS
//  DEBOUNCE_CYC  1_000_000   stable cycles required to accept a level change (20 ms at 50 MHz)
//  LONG_CYC      50_000_000  hold cycles after accepted press before long_pulse (1 s)
//  REPEAT_CYC    10_000_000  cycles between repeat_pulse strobes in long hold (200 ms)
//  SYNC_STAGES   2           synchroniser depth, >=2
//  NUM_MODES     4           mode_idx modulus, >=2
// PORTS
//  sys_clk        in   1                     system clock, 50 MHz
//  sys_rst        in   1                     asynchronous, active-high reset
//  key_n          in   1                     raw key, 0 = pressed, asynchronous to sys_clk
//  key_level      out  1                     debounced level, 1 = pressed
//  press_pulse    out  1                     1-cycle strobe on accepted press
//  release_pulse  out  1                     1-cycle strobe on accepted release
//  short_pulse    out  1                     1-cycle strobe on release when no long_pulse occurred
//  long_pulse     out  1                     1-cycle strobe when hold reaches LONG_CYC
//  repeat_pulse   out  1                     1-cycle strobe every REPEAT_CYC while long-held
//  mode_idx       out  $clog2(NUM_MODES)     current display mode
// BEHAVIOUR
//  Reset:
//   - Asynchronous; takes effect immediately, including mid-operation.
//   - Clears every output to 0 and returns the FSM to IDLE.
//   - Presets the synchroniser flops to 1 (released) and clears all counters and long_flag.
//  Synchroniser: key_s = key_n delayed through SYNC_STAGES flops. The FSM sees only key_s.
//  FSM states: IDLE, DEB_PRESS, HELD, LONG_HELD, DEB_RELEASE.
//   - IDLE:
//     - key_s=0 -> DEB_PRESS; deb_cnt=0.
//   - DEB_PRESS:
//     - key_s=1 -> IDLE; no strobe (bounce rejected).
//     - deb_cnt==DEBOUNCE_CYC-1 -> HELD; press_pulse=1; key_level<=1; hold_cnt=0; long_flag=0.
//   - HELD: hold_cnt increments each cycle.
//     - hold_cnt==LONG_CYC-1 -> LONG_HELD; long_pulse=1; long_flag=1; mode_idx<=0; rep_cnt=0.
//     - key_s=1 -> DEB_RELEASE; deb_cnt=0.
//   - LONG_HELD: rep_cnt increments.
//     - rep_cnt==REPEAT_CYC-1 -> repeat_pulse=1; rep_cnt=0.
//     - key_s=1 -> DEB_RELEASE.
//   - DEB_RELEASE: hold_cnt and rep_cnt freeze.
//     - key_s=0 -> back to HELD or LONG_HELD per long_flag; counters resume.
//     - deb_cnt==DEBOUNCE_CYC-1 -> IDLE; release_pulse=1; key_level<=0.
//       - If !long_flag, also short_pulse=1 and mode_idx<=mode_idx+1.
//  Timing and strobe rules:
//   - With clean input, press_pulse is high during cycle SYNC_STAGES+DEBOUNCE_CYC.
//     Cycle 0 is the first edge that samples key_n=0.
//   - Release strobes follow the same latency, counted from key_n rising.
//   - All strobes are registered and high for exactly one cycle.
//   - press_pulse and release_pulse can never coincide.
//   - short_pulse always coincides with release_pulse.
//  Arithmetic:
//   - mode_idx wraps NUM_MODES-1 -> 0.
//   - Counters are sized $clog2(max count) and never overflow; each saturates at its terminal compare.
//  Simultaneous events:
//   - A long-hold terminal and key_s=1 in the same cycle: long takes priority.
//   - A repeat terminal and key_s=1 in the same cycle: repeat_pulse fires, then DEB_RELEASE.
// STRUCTURE
//  - Shared package key_pkg: FSM state encoding (localparam/enum) and the count-width helper.
//  - Sub-module key_sync: SYNC_STAGES flop chain with reset preset to 1.
//  - Everything else (FSM, counters, mode register) lives in key_event_gen.
//  - Outputs are registered directly, with no combinational path from key_n.
// TESTING  (params: DEBOUNCE_CYC=100, LONG_CYC=5000, REPEAT_CYC=1000, NUM_MODES=4, 20 ns clock)
//  1. Bounce reject:
//     key_n toggles every 20 cycles for 500 cycles, then settles high.
//     -> No strobes; key_level stays 0; mode_idx stays 0.
//  2. Clean 5 us press (250 cycles low):
//     -> press_pulse at cycle 102 after the fall.
//     -> release_pulse and short_pulse together 102 cycles after the rise; mode_idx 0->1.
//  3. Four more short presses:
//     -> mode_idx steps 1->2->3->0->1 (wrap checked); each press gives exactly one press/release pair.
//  4. Hold 10000 cycles:
//     -> long_pulse once at cycle 5102, mode_idx->0.
//     -> repeat_pulse at 6102, 7102, 8102, 9102 (4 total).
//     -> On release: release_pulse with no short_pulse.
//  5. 30-cycle high glitch at cycle 3000 of a HELD press:
//     -> No release_pulse; key_level stays 1.
//     -> long_pulse is delayed by exactly the 30 frozen cycles plus sync (cycle 5132+).
//  6. Assert sys_rst mid-LONG_HELD with key_n still low:
//     -> All outputs 0 immediately, mode_idx=0.
//     -> After sys_rst deasserts, press_pulse fires SYNC_STAGES+DEBOUNCE_CYC cycles later.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and helpers for the push-button event generator.
// Holds the FSM state encoding and the counter width helper.
package key_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    LONG_HELD,
    DEB_RELEASE
  } key_state_t;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_sync.sv
// Multi-flop synchroniser for the asynchronous key input.
// Flops preset to 1 so a reset reads as "released".
module key_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= '1;
    else     sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/key_event_gen.sv
// Debounced key front end: press/release/short/long/repeat strobes
// and a wrapping display-mode index.
module key_event_gen
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 50_000_000,
  parameter int REPEAT_CYC   = 10_000_000,
  parameter int SYNC_STAGES  = 2,
  parameter int NUM_MODES    = 4
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic                         key_n,
  output logic                         key_level,
  output logic                         press_pulse,
  output logic                         release_pulse,
  output logic                         short_pulse,
  output logic                         long_pulse,
  output logic                         repeat_pulse,
  output logic [cnt_w(NUM_MODES)-1:0]  mode_idx
);

  localparam int DW = cnt_w(DEBOUNCE_CYC);
  localparam int HW = cnt_w(LONG_CYC);
  localparam int RW = cnt_w(REPEAT_CYC);
  localparam int MW = cnt_w(NUM_MODES);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYC - 1);
  localparam logic [MW-1:0] MODE_LAST = MW'(NUM_MODES - 1);

  logic key_s;

  key_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (sys_clk),
    .rst (sys_rst),
    .d   (key_n),
    .q   (key_s)
  );

  key_state_t      state, state_n;
  logic [DW-1:0]   deb_cnt, deb_n;
  logic [HW-1:0]   hold_cnt, hold_n;
  logic [RW-1:0]   rep_cnt, rep_n;
  logic            long_flag, flag_n;
  logic            level_n;
  logic [MW-1:0]   mode_n;
  logic            press_n, rel_n, short_n;
  logic            long_n, rep_p_n;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state         <= IDLE;
      deb_cnt       <= '0;
      hold_cnt      <= '0;
      rep_cnt       <= '0;
      long_flag     <= 1'b0;
      key_level     <= 1'b0;
      mode_idx      <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      state         <= state_n;
      deb_cnt       <= deb_n;
      hold_cnt      <= hold_n;
      rep_cnt       <= rep_n;
      long_flag     <= flag_n;
      key_level     <= level_n;
      mode_idx      <= mode_n;
      press_pulse   <= press_n;
      release_pulse <= rel_n;
      short_pulse   <= short_n;
      long_pulse    <= long_n;
      repeat_pulse  <= rep_p_n;
    end
  end

  always_comb begin
    state_n = state;
    deb_n   = deb_cnt;
    hold_n  = hold_cnt;
    rep_n   = rep_cnt;
    flag_n  = long_flag;
    level_n = key_level;
    mode_n  = mode_idx;
    press_n = 1'b0;
    rel_n   = 1'b0;
    short_n = 1'b0;
    long_n  = 1'b0;
    rep_p_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (!key_s) begin
          state_n = DEB_PRESS;
          deb_n   = '0;
        end
      end
      DEB_PRESS: begin
        if (key_s) begin
          state_n = IDLE;
        end else if (deb_cnt == DEB_LAST) begin
          state_n = HELD;
          press_n = 1'b1;
          level_n = 1'b1;
          hold_n  = '0;
          flag_n  = 1'b0;
        end else begin
          deb_n = deb_cnt + 1'b1;
        end
      end
      // Long terminal wins over a coincident release.
      HELD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_n = LONG_HELD;
          long_n  = 1'b1;
          flag_n  = 1'b1;
          mode_n  = '0;
          rep_n   = '0;
        end else begin
          hold_n = hold_cnt + 1'b1;
          if (key_s) begin
            state_n = DEB_RELEASE;
            deb_n   = '0;
          end
        end
      end
      LONG_HELD: begin
        if (rep_cnt == REP_LAST) begin
          rep_p_n = 1'b1;
          rep_n   = '0;
        end else begin
          rep_n = rep_cnt + 1'b1;
        end
        if (key_s) begin
          state_n = DEB_RELEASE;
          deb_n   = '0;
        end
      end
      DEB_RELEASE: begin
        if (!key_s) begin
          state_n = long_flag ? LONG_HELD : HELD;
        end else if (deb_cnt == DEB_LAST) begin
          state_n = IDLE;
          rel_n   = 1'b1;
          level_n = 1'b0;
          if (!long_flag) begin
            short_n = 1'b1;
            mode_n  = (mode_idx == MODE_LAST) ? '0 : mode_idx + 1'b1;
          end
        end else begin
          deb_n = deb_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_key_event_gen.sv
// Directed bench for key_event_gen with shortened timing constants.
// Each scenario task drives the key and checks strobe timing inline.
module tb_key_event_gen;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       key_n   = 1'b1;
  logic       key_level;
  logic       press_pulse, release_pulse, short_pulse;
  logic       long_pulse, repeat_pulse;
  logic [1:0] mode_idx;

  int vec = 0;
  int bad = 0;

  int cyc;
  int n_press, t_press, n_rel, t_rel, n_short, t_short;
  int n_long, t_long, n_rep, t_rep_first, t_rep_last;
  int n_coinc, n_orphan;
  logic [1:0] mode_at_long;

  always #10 sys_clk = ~sys_clk;

  key_event_gen #(
    .DEBOUNCE_CYC (100),
    .LONG_CYC     (5000),
    .REPEAT_CYC   (1000),
    .SYNC_STAGES  (2),
    .NUM_MODES    (4)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .key_n         (key_n),
    .key_level     (key_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .short_pulse   (short_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .mode_idx      (mode_idx)
  );

  task automatic clear_stats();
    cyc = -1;
    n_press = 0; t_press = -1;
    n_rel = 0;   t_rel = -1;
    n_short = 0; t_short = -1;
    n_long = 0;  t_long = -1;
    n_rep = 0;   t_rep_first = -1; t_rep_last = -1;
    n_coinc = 0; n_orphan = 0;
    mode_at_long = 2'd3;
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
    cyc++;
    if (press_pulse)   begin n_press++; t_press = cyc; end
    if (release_pulse) begin n_rel++;   t_rel = cyc;   end
    if (short_pulse)   begin n_short++; t_short = cyc; end
    if (long_pulse) begin
      n_long++; t_long = cyc; mode_at_long = mode_idx;
    end
    if (repeat_pulse) begin
      if (n_rep == 0) t_rep_first = cyc;
      n_rep++; t_rep_last = cyc;
    end
    if (press_pulse && release_pulse) n_coinc++;
    if (short_pulse && !release_pulse) n_orphan++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_press(input int low_cyc, input int tail);
    clear_stats();
    key_n = 1'b0;
    steps(low_cyc);
    key_n = 1'b1;
    steps(tail);
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    key_n = 1'b1;
    clear_stats();
    steps(3);
    vec++;
    if ({key_level, press_pulse, release_pulse, short_pulse,
         long_pulse, repeat_pulse, mode_idx} !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs got=%b%b%b%b%b%b mode=%0d want all 0",
               key_level, press_pulse, release_pulse, short_pulse,
               long_pulse, repeat_pulse, mode_idx);
    end
    sys_rst = 1'b0;
    steps(5);
  endtask

  task automatic test_bounce();
    clear_stats();
    for (int i = 0; i < 25; i++) begin
      key_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      steps(20);
    end
    key_n = 1'b1;
    steps(200);
    vec++;
    if (n_press + n_rel + n_short + n_long + n_rep !== 0) begin
      bad++;
      $display("FAIL bounce_strobes got=%0d/%0d/%0d/%0d/%0d want 0",
               n_press, n_rel, n_short, n_long, n_rep);
    end
    vec++;
    if (key_level !== 1'b0 || mode_idx !== 2'd0) begin
      bad++;
      $display("FAIL bounce_state level=%b mode=%0d want 0/0",
               key_level, mode_idx);
    end
  endtask

  task automatic test_short_press();
    do_press(250, 200);
    vec++;
    if (n_press !== 1 || t_press !== 102) begin
      bad++;
      $display("FAIL short_press_time n=%0d t=%0d want 1 at 102",
               n_press, t_press);
    end
    vec++;
    if (n_rel !== 1 || t_rel !== 352) begin
      bad++;
      $display("FAIL short_release_time n=%0d t=%0d want 1 at 352",
               n_rel, t_rel);
    end
    vec++;
    if (n_short !== 1 || t_short !== 352 || n_orphan !== 0) begin
      bad++;
      $display("FAIL short_pulse n=%0d t=%0d want 1 at 352",
               n_short, t_short);
    end
    vec++;
    if (mode_idx !== 2'd1 || n_coinc !== 0 || n_long !== 0) begin
      bad++;
      $display("FAIL short_mode got=%0d long=%0d want 1/0",
               mode_idx, n_long);
    end
  endtask

  task automatic test_mode_wrap();
    logic [1:0] exp_mode [4];
    exp_mode[0] = 2'd2; exp_mode[1] = 2'd3;
    exp_mode[2] = 2'd0; exp_mode[3] = 2'd1;
    for (int k = 0; k < 4; k++) begin
      do_press(250, 200);
      vec++;
      if (mode_idx !== exp_mode[k] || n_press !== 1 || n_rel !== 1) begin
        bad++;
        $display("FAIL wrap_%0d mode=%0d press=%0d rel=%0d want %0d/1/1",
                 k, mode_idx, n_press, n_rel, exp_mode[k]);
      end
    end
  endtask

  task automatic test_long_hold();
    do_press(10000, 200);
    vec++;
    if (n_long !== 1 || t_long !== 5102 || mode_at_long !== 2'd0) begin
      bad++;
      $display("FAIL long_time n=%0d t=%0d mode=%0d want 1 at 5102 mode 0",
               n_long, t_long, mode_at_long);
    end
    vec++;
    if (n_rep !== 4 || t_rep_first !== 6102 || t_rep_last !== 9102) begin
      bad++;
      $display("FAIL repeat n=%0d first=%0d last=%0d want 4/6102/9102",
               n_rep, t_rep_first, t_rep_last);
    end
    vec++;
    if (n_rel !== 1 || t_rel !== 10102 || n_short !== 0) begin
      bad++;
      $display("FAIL long_release n=%0d t=%0d short=%0d want 1/10102/0",
               n_rel, t_rel, n_short);
    end
    vec++;
    if (mode_idx !== 2'd0 || key_level !== 1'b0) begin
      bad++;
      $display("FAIL long_end mode=%0d level=%b want 0/0",
               mode_idx, key_level);
    end
  endtask

  task automatic test_glitch();
    clear_stats();
    key_n = 1'b0;
    steps(3000);
    key_n = 1'b1;
    steps(30);
    key_n = 1'b0;
    steps(10);
    vec++;
    if (key_level !== 1'b1 || n_rel !== 0) begin
      bad++;
      $display("FAIL glitch_level level=%b rel=%0d want 1/0",
               key_level, n_rel);
    end
    steps(2160);
    vec++;
    if (n_long !== 1 || t_long !== 5132) begin
      bad++;
      $display("FAIL glitch_long n=%0d t=%0d want 1 at 5132",
               n_long, t_long);
    end
    key_n = 1'b1;
    steps(200);
    vec++;
    if (n_rel !== 1 || t_rel !== 5302 || n_short !== 0) begin
      bad++;
      $display("FAIL glitch_release n=%0d t=%0d short=%0d want 1/5302/0",
               n_rel, t_rel, n_short);
    end
  endtask

  task automatic test_reset_mid_hold();
    do_press(250, 200);
    clear_stats();
    key_n = 1'b0;
    steps(5500);
    vec++;
    if (n_long !== 1 || key_level !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset long=%0d level=%b want 1/1",
               n_long, key_level);
    end
    sys_rst = 1'b1;
    #1;
    vec++;
    if ({key_level, press_pulse, release_pulse, short_pulse,
         long_pulse, repeat_pulse, mode_idx} !== 8'h00) begin
      bad++;
      $display("FAIL async_reset level=%b mode=%0d want all 0",
               key_level, mode_idx);
    end
    steps(3);
    sys_rst = 1'b0;
    clear_stats();
    steps(150);
    vec++;
    if (n_press !== 1 || t_press !== 102 || key_level !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_press n=%0d t=%0d level=%b want 1 at 102",
               n_press, t_press, key_level);
    end
    key_n = 1'b1;
    steps(200);
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_short_press();
    test_mode_wrap();
    test_long_hold();
    test_glitch();
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
